// File: rtl/elink_downlink_writer.sv
// rtl/elink_downlink_writer.sv - buffers 76-bit core response frames and serializes them as SOP/10-byte/EOP e-link packets
module elink_downlink_writer #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] SOP_BYTE = 8'h3C,
    parameter logic [7:0] EOP_BYTE = 8'hDC
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_write_elink,
    input  logic [75:0]                  data_rec_uplink,
    output logic                         end_write_elink,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         busy,
    output logic [15:0]                  frame_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SOP  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_EOP  = 2'd3;

    logic [75:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          armed_q, armed_d;
    logic          ack_q, ack_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    bidx_q, bidx_d;
    logic [79:0]   shift_q, shift_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic [15:0]   fcnt_q, fcnt_d;

    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        accept;
    logic [75:0] head;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign push       = start_write_elink && armed_q && (count_q != CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign accept     = tx_valid_q && tx_ready;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        armed_d = armed_q;
        if (push) begin
            armed_d = 1'b0;
        end else if (!start_write_elink) begin
            armed_d = 1'b1;
        end
        ack_d = push;
    end

    always_comb begin
        state_d    = state_q;
        bidx_d     = bidx_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        fcnt_d     = fcnt_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = {4'b0000, head};
                    state_d    = ST_SOP;
                    tx_data_d  = SOP_BYTE;
                    tx_valid_d = 1'b1;
                end
            end
            ST_SOP: begin
                if (accept) begin
                    state_d   = ST_DATA;
                    bidx_d    = 4'd0;
                    tx_data_d = shift_q[79:72];
                    shift_d   = {shift_q[71:0], 8'h00};
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (bidx_q == 4'd9) begin
                        state_d   = ST_EOP;
                        tx_data_d = EOP_BYTE;
                    end else begin
                        bidx_d    = bidx_q + 4'd1;
                        tx_data_d = shift_q[79:72];
                        shift_d   = {shift_q[71:0], 8'h00};
                    end
                end
            end
            ST_EOP: begin
                if (accept) begin
                    fcnt_d = fcnt_q + 16'd1;
                    // Chain straight into the next packet so queued frames leave with no idle byte slot.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = {4'b0000, head};
                        state_d   = ST_SOP;
                        tx_data_d = SOP_BYTE;
                    end else begin
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_rec_uplink;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            armed_q    <= 1'b1;
            ack_q      <= 1'b0;
            state_q    <= ST_IDLE;
            bidx_q     <= 4'd0;
            shift_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            fcnt_q     <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            armed_q    <= armed_d;
            ack_q      <= ack_d;
            state_q    <= state_d;
            bidx_q     <= bidx_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign end_write_elink = ack_q;
    assign tx_data         = tx_data_q;
    assign tx_valid        = tx_valid_q;
    assign fifo_level      = count_q;
    assign busy            = (state_q != ST_IDLE) || !fifo_empty;
    assign frame_count     = fcnt_q;
endmodule

// File: tb/tb_elink_downlink_writer.sv
// tb/tb_elink_downlink_writer.sv - directed vector bench for elink_downlink_writer
module tb_elink_downlink_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_write_elink = 1'b0;
    logic [75:0] data_rec_uplink = '0;
    logic        end_write_elink;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [2:0]  fifo_level;
    logic        busy;
    logic [15:0] frame_count;

    elink_downlink_writer dut (
        .clk               (clk),
        .rst               (rst),
        .start_write_elink (start_write_elink),
        .data_rec_uplink   (data_rec_uplink),
        .end_write_elink   (end_write_elink),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .fifo_level        (fifo_level),
        .busy              (busy),
        .frame_count       (frame_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ack_cnt = 0;
    int cyc_cnt = 0;
    int ready_mode = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    typedef struct {
        logic [75:0] frame;
        bit          toggle;
        logic [95:0] exp;
    } vec_t;

    vec_t        vecs[5];
    logic [75:0] fr[6];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [75:0] f, input int i);
        logic [79:0] w;
        if (i == 0) return 8'h3C;
        if (i == 11) return 8'hDC;
        w = {4'b0000, f} >> (8 * (10 - i));
        return w[7:0];
    endfunction

    function automatic logic [95:0] pkt_exp(input logic [75:0] f);
        logic [95:0] r = '0;
        for (int i = 0; i < 12; i++) r = {r[87:0], model_byte(f, i)};
        return r;
    endfunction

    function automatic logic [95:0] pkt_act(input int base);
        logic [95:0] r = '0;
        for (int i = 0; i < 12; i++) r = {r[87:0], rx_q[base + i]};
        return r;
    endfunction

    always @(posedge clk) begin
        cyc_cnt++;
        #2;
        case (ready_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = !tx_ready;
        endcase
    end

    // Byte collector and stall-hold check, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", {tx_valid, tx_data}, {1'b1, prev_data});
            if (end_write_elink) ack_cnt++;
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_data);
                rx_t.push_back(cyc_cnt);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [75:0] f, input int bound, output bit ok);
        start_write_elink = 1'b1;
        data_rec_uplink   = f;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (end_write_elink) begin
                ok = 1'b1;
                break;
            end
        end
        start_write_elink = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    initial begin
        bit ok;
        int ack0;
        int gaps;
        logic [15:0] fc0;

        vecs[0] = '{76'hA0123456789ABCDEF12, 1'b0, 96'h3C0A_0123_4567_89AB_CDEF_12DC};
        vecs[1] = '{76'hA0123456789ABCDEF12, 1'b1, 96'h3C0A_0123_4567_89AB_CDEF_12DC};
        vecs[2] = '{76'hFFFFFFFFFFFFFFFFFFF, 1'b0, 96'h3C0F_FFFF_FFFF_FFFF_FFFF_FFDC};
        vecs[3] = '{76'h5000000000000000001, 1'b1, 96'h3C05_0000_0000_0000_0000_01DC};
        vecs[4] = '{76'hC3A5A5A5A5A5A5A5AA5, 1'b1, 96'h3C0C_3A5A_5A5A_5A5A_5A5A_A5DC};
        for (int i = 0; i < 6; i++) begin
            fr[i] = {4'(i + 1), 8'(16 * i + 7), 64'hFEDC_BA98_7654_3210 ^ 64'(i * 3 + 1)};
        end

        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("reset_outputs", {end_write_elink, tx_valid, tx_data, fifo_level, busy, frame_count},
            {1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 16'h0000});

        // Single frames, free-running and back-pressured.
        for (int v = 0; v < 5; v++) begin
            ready_mode = vecs[v].toggle ? 2 : 1;
            rx_q.delete();
            rx_t.delete();
            fc0 = frame_count;
            push(vecs[v].frame, 1, ok);
            chk("ack_latency", ok, 1);
            cyc(1);
            chk("sop_latency", {tx_valid, tx_data}, {1'b1, 8'h3C});
            wait_bytes(12, 60, ok);
            chk("packet_done", ok, 1);
            chk("packet_bytes", pkt_act(0), vecs[v].exp);
            chk("frame_count_inc", frame_count - fc0, 1);
            cyc(1);
            chk("idle_after", {busy, tx_valid, fifo_level, 4'(rx_q.size())}, {1'b0, 1'b0, 3'd0, 4'd12});
        end

        // Full FIFO: the first frame sits in the serializer, so five pushes fill four slots.
        ready_mode = 0;
        cyc(2);
        rx_q.delete();
        rx_t.delete();
        ack0 = ack_cnt;
        fc0  = frame_count;
        for (int k = 0; k < 5; k++) begin
            push(fr[k], 2, ok);
            chk("full_push_ack", ok, 1);
            cyc(1);
        end
        chk("full_acks", ack_cnt - ack0, 5);
        chk("full_level", fifo_level, 4);
        start_write_elink = 1'b1;
        data_rec_uplink   = fr[5];
        cyc(10);
        chk("full_no_ack", ack_cnt - ack0, 5);
        chk("full_level_hold", {fifo_level, busy}, {3'd4, 1'b1});
        ready_mode = 1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (end_write_elink) begin
                ok = 1'b1;
                break;
            end
        end
        chk("full_late_ack", ok, 1);
        chk("full_ack_after_pop", frame_count - fc0, 1);
        start_write_elink = 1'b0;
        wait_bytes(72, 200, ok);
        chk("full_drain", ok, 1);
        for (int p = 0; p < 6; p++) chk("full_order", pkt_act(p * 12), pkt_exp(fr[p]));
        chk("full_frames", frame_count - fc0, 6);

        // Held request: one ack only.
        ready_mode = 0;
        cyc(2);
        rx_q.delete();
        rx_t.delete();
        ack0 = ack_cnt;
        start_write_elink = 1'b1;
        data_rec_uplink   = fr[2];
        cyc(20);
        start_write_elink = 1'b0;
        cyc(2);
        chk("held_one_ack", ack_cnt - ack0, 1);
        chk("held_queued", {busy, fifo_level}, {1'b1, 3'd0});
        ready_mode = 1;
        wait_bytes(12, 60, ok);
        chk("held_packet", pkt_act(0), pkt_exp(fr[2]));
        cyc(20);
        chk("held_no_extra", {4'(rx_q.size()), busy, fifo_level}, {4'd12, 1'b0, 3'd0});

        // Back-to-back packets with no gap.
        ready_mode = 0;
        cyc(2);
        rx_q.delete();
        rx_t.delete();
        fc0 = frame_count;
        push(fr[3], 2, ok); cyc(1);
        push(fr[4], 2, ok); cyc(1);
        push(fr[0], 2, ok); cyc(1);
        chk("b2b_level", fifo_level, 2);
        ready_mode = 1;
        wait_bytes(36, 120, ok);
        chk("b2b_done", ok, 1);
        chk("b2b_pkt0", pkt_act(0), pkt_exp(fr[3]));
        chk("b2b_pkt1", pkt_act(12), pkt_exp(fr[4]));
        chk("b2b_pkt2", pkt_act(24), pkt_exp(fr[0]));
        gaps = 0;
        for (int i = 1; i < 36; i++) if (rx_t[i] != rx_t[i - 1] + 1) gaps++;
        chk("b2b_gaps", gaps, 0);
        chk("b2b_frames", frame_count - fc0, 3);

        // Reset in the middle of DATA b=4 with a second frame queued.
        ready_mode = 0;
        cyc(2);
        rx_q.delete();
        rx_t.delete();
        push(fr[1], 2, ok); cyc(1);
        push(fr[2], 2, ok); cyc(1);
        ready_mode = 1;
        wait_bytes(5, 40, ok);
        chk("pre_reset_byte", {ok, tx_valid, tx_data}, {1'b1, 1'b1, model_byte(fr[1], 5)});
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_reset", {tx_valid, fifo_level, busy, frame_count}, {1'b0, 3'd0, 1'b0, 16'h0000});
        cyc(3);
        chk("mid_reset_quiet", {tx_valid, busy}, {1'b0, 1'b0});
        rx_q.delete();
        rx_t.delete();
        push(fr[5], 1, ok);
        chk("post_reset_ack", ok, 1);
        cyc(1);
        chk("post_reset_sop", {tx_valid, tx_data}, {1'b1, 8'h3C});
        wait_bytes(12, 60, ok);
        chk("post_reset_packet", pkt_act(0), pkt_exp(fr[5]));
        chk("post_reset_count", frame_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
